hazard_scheduler: RTL and testbench

//  Pipeline sequencer for the RV32I decode/execute datapath. Tracks the destination

---
 rtl/hazard_scheduler.sv | 126 ++++++++++++
 tb/tb_hazard_scheduler.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/hazard_scheduler.sv
// rtl/hazard_scheduler.sv - RV32I decode-stage hazard scheduler: stall, bubble, flush and forwarding selects
module hazard_scheduler #(
    parameter int REG_ADDR = 5,
    parameter int FWD_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [REG_ADDR-1:0] id_rs1,
    input  logic [REG_ADDR-1:0] id_rs2,
    input  logic                id_use_rs1,
    input  logic                id_use_rs2,
    input  logic [REG_ADDR-1:0] id_rd,
    input  logic                id_reg_write,
    input  logic                id_load,
    input  logic                id_mem,
    input  logic                ex_branch_taken,
    input  logic                mem_ready,
    output logic                pc_stall,
    output logic                if_id_stall,
    output logic                id_ex_bubble,
    output logic                if_id_flush,
    output logic [FWD_W-1:0]    fwd_a_sel,
    output logic [FWD_W-1:0]    fwd_b_sel,
    output logic [1:0]          state_o
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_STALL = 2'b01,
        MEM_WAIT = 2'b10
    } state_t;

    typedef struct packed {
        logic                valid;
        logic [REG_ADDR-1:0] rd;
        logic                reg_write;
        logic                load;
        logic                mem;
    } slot_t;

    localparam logic [FWD_W-1:0] FWD_RF  = FWD_W'(0);
    localparam logic [FWD_W-1:0] FWD_EX  = FWD_W'(1);
    localparam logic [FWD_W-1:0] FWD_MEM = FWD_W'(2);
    localparam logic [FWD_W-1:0] FWD_WB  = FWD_W'(3);

    state_t state, state_nxt;
    slot_t  ex_slot, mem_slot, wb_slot;

    logic             mem_wait;
    logic             flush;
    logic             load_use;
    logic             issue;
    logic             lu_a, lu_b;

    function automatic logic hit(input slot_t s, input logic [REG_ADDR-1:0] rs, input logic use_rs);
        return use_rs && (rs != '0) && s.valid && s.reg_write && (s.rd == rs);
    endfunction

    // The youngest matching slot decides both the select and whether the value is
    // still in flight from a load; an older load is shadowed by a younger writer.
    function automatic logic [FWD_W:0] resolve(input slot_t ex_s, input slot_t mem_s,
                                               input slot_t wb_s,
                                               input logic [REG_ADDR-1:0] rs,
                                               input logic use_rs);
        if (hit(ex_s, rs, use_rs))
            return ex_s.load ? {1'b1, FWD_RF} : {1'b0, FWD_EX};
        else if (hit(mem_s, rs, use_rs))
            return mem_s.load ? {1'b1, FWD_RF} : {1'b0, FWD_MEM};
        else if (hit(wb_s, rs, use_rs))
            return {1'b0, FWD_WB};
        else
            return {1'b0, FWD_RF};
    endfunction

    assign {lu_a, fwd_a_sel} = resolve(ex_slot, mem_slot, wb_slot, id_rs1, id_use_rs1);
    assign {lu_b, fwd_b_sel} = resolve(ex_slot, mem_slot, wb_slot, id_rs2, id_use_rs2);

    assign mem_wait = mem_slot.valid && mem_slot.mem && !mem_ready;
    assign flush    = ex_branch_taken && ex_slot.valid;
    assign load_use = id_valid && (lu_a || lu_b);
    assign issue    = id_valid && !id_ex_bubble && !if_id_flush;
    assign state_o  = state;

    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        state_nxt    = RUN;
        if (mem_wait) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            state_nxt   = MEM_WAIT;
        end else if (flush) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (load_use) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
            state_nxt    = LU_STALL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            ex_slot  <= '0;
            mem_slot <= '0;
            wb_slot  <= '0;
        end else begin
            state <= state_nxt;
            if (!mem_wait) begin
                wb_slot  <= mem_slot;
                mem_slot <= ex_slot;
                if (issue)
                    ex_slot <= '{valid: 1'b1, rd: id_rd, reg_write: id_reg_write,
                                 load: id_load, mem: id_mem};
                else
                    ex_slot <= '0;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scheduler.sv
// tb/tb_hazard_scheduler.sv - directed scoreboard bench for hazard_scheduler
module tb_hazard_scheduler;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_use_rs1, id_use_rs2;
    logic       id_reg_write, id_load, id_mem;
    logic       ex_branch_taken, mem_ready;
    logic       pc_stall, if_id_stall, id_ex_bubble, if_id_flush;
    logic [1:0] fwd_a_sel, fwd_b_sel, state_o;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        string      tag;
        logic [9:0] exp;
    } exp_t;
    exp_t sb[$];

    hazard_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_use_rs1     (id_use_rs1),
        .id_use_rs2     (id_use_rs2),
        .id_rd          (id_rd),
        .id_reg_write   (id_reg_write),
        .id_load        (id_load),
        .id_mem         (id_mem),
        .ex_branch_taken(ex_branch_taken),
        .mem_ready      (mem_ready),
        .pc_stall       (pc_stall),
        .if_id_stall    (if_id_stall),
        .id_ex_bubble   (id_ex_bubble),
        .if_id_flush    (if_id_flush),
        .fwd_a_sel      (fwd_a_sel),
        .fwd_b_sel      (fwd_b_sel),
        .state_o        (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_stall, if_id_stall, id_ex_bubble, if_id_flush, fwd_a, fwd_b, state}
    function automatic logic [9:0] mk(input logic ps, input logic is, input logic bb,
                                      input logic fl, input logic [1:0] fa,
                                      input logic [1:0] fb, input logic [1:0] st);
        return {ps, is, bb, fl, fa, fb, st};
    endfunction

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                          input logic rw, input logic ld, input logic mem);
        id_valid     = v;
        id_rs1       = rs1;
        id_use_rs1   = u1;
        id_rs2       = rs2;
        id_use_rs2   = u2;
        id_rd        = rd;
        id_reg_write = rw;
        id_load      = ld;
        id_mem       = mem;
    endtask

    task automatic step(input string tag, input logic [9:0] e);
        exp_t       x;
        logic [9:0] obs;
        x.tag = tag;
        x.exp = e;
        sb.push_back(x);
        @(negedge clk);
        x   = sb.pop_front();
        obs = {pc_stall, if_id_stall, id_ex_bubble, if_id_flush, fwd_a_sel, fwd_b_sel, state_o};
        n_cmp++;
        assert (obs === x.exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", x.tag, obs, x.exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(tag, mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    endtask

    initial begin
        rst             = 1'b1;
        ex_branch_taken = 1'b0;
        mem_ready       = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("reset", mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        rst = 1'b0;

        // ALU forwarding from EX/MEM/WB and x0 exclusion
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0);
        step("t2_add_x5", mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        set_id(1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 0);
        step("t2_fwd_ex", mk(0, 0, 0, 0, 2'b01, 2'b01, 2'b00));
        set_id(1, 5'd6, 1, 5'd5, 1, 5'd0, 1, 0, 0);
        step("t2_fwd_ex_mem", mk(0, 0, 0, 0, 2'b01, 2'b10, 2'b00));
        set_id(1, 5'd0, 1, 5'd5, 1, 5'd0, 0, 0, 0);
        step("t2_x0_wb", mk(0, 0, 0, 0, 2'b00, 2'b11, 2'b00));
        drain("t2_drain");

        // Load-use: two bubbles, then forward from WB
        set_id(1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 1, 1);
        step("t3_lw", mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        set_id(1, 5'd7, 1, 5'd1, 1, 5'd8, 1, 0, 0);
        step("t3_lu_ex", mk(1, 1, 1, 0, 2'b00, 2'b00, 2'b00));
        step("t3_lu_mem", mk(1, 1, 1, 0, 2'b00, 2'b00, 2'b01));
        step("t3_fwd_wb", mk(0, 0, 0, 0, 2'b11, 2'b00, 2'b01));
        drain("t3_drain");

        // Taken branch in EX kills a load-use dependent in ID
        set_id(1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 1, 1);
        step("t4_lw", mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd0, 0, 0, 0);
        step("t4_beq", mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        set_id(1, 5'd7, 1, 5'd1, 1, 5'd8, 1, 0, 0);
        ex_branch_taken = 1'b1;
        step("t4_flush", mk(0, 0, 1, 1, 2'b00, 2'b00, 2'b00));
        ex_branch_taken = 1'b0;
        drain("t4_drain");

        // Store stalled in MEM freezes the pipe; branch input ignored while frozen
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd0, 0, 0, 1);
        step("t5_sw", mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd9, 1, 0, 0);
        step("t5_add_x9", mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        set_id(1, 5'd9, 1, 5'd0, 1, 5'd10, 1, 0, 0);
        mem_ready = 1'b0;
        step("t5_wait1", mk(1, 1, 0, 0, 2'b01, 2'b00, 2'b00));
        ex_branch_taken = 1'b1;
        step("t5_wait2", mk(1, 1, 0, 0, 2'b01, 2'b00, 2'b10));
        ex_branch_taken = 1'b0;
        step("t5_wait3", mk(1, 1, 0, 0, 2'b01, 2'b00, 2'b10));
        mem_ready = 1'b1;
        step("t5_release", mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b10));
        set_id(1, 5'd9, 1, 5'd0, 0, 5'd0, 0, 0, 1);
        step("t5_slots_kept", mk(0, 0, 0, 0, 2'b10, 2'b00, 2'b00));
        drain("t5_drain");

        // Younger ALU write shadows an older load to the same register
        set_id(1, 5'd1, 1, 5'd0, 0, 5'd9, 1, 1, 1);
        step("t6_lw_x9", mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd9, 1, 0, 0);
        step("t6_add_x9", mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        set_id(1, 5'd9, 1, 5'd9, 1, 5'd11, 1, 0, 0);
        step("t6_youngest", mk(0, 0, 0, 0, 2'b01, 2'b01, 2'b00));
        drain("t6_drain");

        // Asynchronous reset while in LU_STALL
        set_id(1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 1, 1);
        step("t1_lw", mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        set_id(1, 5'd7, 1, 5'd1, 1, 5'd8, 1, 0, 0);
        step("t1_lu", mk(1, 1, 1, 0, 2'b00, 2'b00, 2'b00));
        rst = 1'b1;
        step("t1_rst_mid", mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        rst = 1'b0;
        step("t1_post_rst", mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
